// File: rtl/hfc_pkg.sv
// Shared types and constants for the EX-stage hazard/forwarding controller.
package hfc_pkg;

  localparam int unsigned SHADOW_AW = 5;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_EXMM = 2'b01;
  localparam logic [1:0] FWD_MMWB = 2'b10;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MD_WAIT    = 2'd2
  } hfc_state_e;

  // Full register-tag metadata of the instruction sitting in EX.
  typedef struct packed {
    logic                 valid;
    logic [SHADOW_AW-1:0] rs;
    logic [SHADOW_AW-1:0] rt;
    logic                 use_rs;
    logic                 use_rt;
    logic [SHADOW_AW-1:0] rd;
    logic                 regwrite;
    logic                 memread;
    logic                 md_start;
  } rr_ex_t;

  // Only the destination tag matters once an instruction has left EX.
  typedef struct packed {
    logic                 regwrite;
    logic [SHADOW_AW-1:0] rd;
  } fwd_src_t;

  typedef struct packed {
    fwd_src_t src;
    logic     memread;
  } ex_mm_t;

endpackage

// File: rtl/hfc_md_counter.sv
// Mul/div occupancy down-counter with a registered zero flag.
module hfc_md_counter #(
  parameter int unsigned CNT_W    = 3,
  parameter int unsigned LOAD_VAL = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  logic [CNT_W-1:0] count_q;

  // Load has priority so a back-to-back mul/div restarts cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      zero    <= 1'b1;
    end else if (load) begin
      count_q <= CNT_W'(LOAD_VAL);
      zero    <= (LOAD_VAL == 0);
    end else if (dec && !zero) begin
      count_q <= count_q - CNT_W'(1);
      zero    <= (count_q == CNT_W'(1));
    end
  end

endmodule

// File: rtl/hazard_forwarding_ctrl.sv
// EX operand forwarding selects plus load-use and mul/div stall control,
// driven from a private shadow pipeline of register tags.
module hazard_forwarding_ctrl
  import hfc_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned MD_LATENCY = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_rr,
  input  logic [REG_AW-1:0] rs_rr,
  input  logic [REG_AW-1:0] rt_rr,
  input  logic              use_rs_rr,
  input  logic              use_rt_rr,
  input  logic [REG_AW-1:0] rd_rr,
  input  logic              regwrite_rr,
  input  logic              memread_rr,
  input  logic              md_start_rr,
  input  logic              md_use_rr,
  input  logic              flush_ex,
  output logic [1:0]        Forwarding_control_1,
  output logic [1:0]        Forwarding_control_2,
  output logic              stall_pc,
  output logic              bubble_rr_ex,
  output logic              md_busy
);

  rr_ex_t     rr_in;
  rr_ex_t     rr_ex;
  ex_mm_t     ex_mm;
  fwd_src_t   mm_wb;
  hfc_state_e state;
  hfc_state_e state_next;

  logic load_use;
  logic md_hazard;
  logic md_enter;
  logic cnt_zero;
  logic cnt_load;
  logic cnt_dec;

  // RR-stage instruction packed into shadow form.
  always_comb begin
    rr_in          = '0;
    rr_in.valid    = valid_rr;
    rr_in.rs       = SHADOW_AW'(rs_rr);
    rr_in.rt       = SHADOW_AW'(rt_rr);
    rr_in.use_rs   = use_rs_rr;
    rr_in.use_rt   = use_rt_rr;
    rr_in.rd       = SHADOW_AW'(rd_rr);
    rr_in.regwrite = regwrite_rr;
    rr_in.memread  = memread_rr;
    rr_in.md_start = md_start_rr;
  end

  // Shadow pipeline; a bubble or flush turns the EX slot into a NOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ex <= '0;
      ex_mm <= '0;
      mm_wb <= '0;
    end else begin
      rr_ex             <= bubble_rr_ex ? '0 : rr_in;
      ex_mm.src.regwrite <= rr_ex.regwrite;
      ex_mm.src.rd       <= rr_ex.rd;
      ex_mm.memread      <= rr_ex.memread;
      mm_wb             <= ex_mm.src;
    end
  end

  // Nearest producer wins; r0 and unused or invalid sources never forward.
  function automatic logic [1:0] fwd_sel(
    input logic                 vld,
    input logic                 use_src,
    input logic [SHADOW_AW-1:0] src,
    input fwd_src_t             exmm,
    input fwd_src_t             mmwb
  );
    fwd_sel = FWD_RF;
    if (vld && use_src && (src != '0)) begin
      if (exmm.regwrite && (exmm.rd == src)) begin
        fwd_sel = FWD_EXMM;
      end else if (mmwb.regwrite && (mmwb.rd == src)) begin
        fwd_sel = FWD_MMWB;
      end
    end
  endfunction

  always_comb begin
    Forwarding_control_1 = fwd_sel(rr_ex.valid, rr_ex.use_rs, rr_ex.rs, ex_mm.src, mm_wb);
    Forwarding_control_2 = fwd_sel(rr_ex.valid, rr_ex.use_rt, rr_ex.rt, ex_mm.src, mm_wb);
  end

  // Hazard detection against the load currently in EX.
  always_comb begin
    load_use = 1'b0;
    if (valid_rr && rr_ex.memread && (rr_ex.rd != '0)) begin
      load_use = (use_rs_rr && (rr_in.rs == rr_ex.rd)) ||
                 (use_rt_rr && (rr_in.rt == rr_ex.rd));
    end
  end

  assign md_enter = rr_ex.md_start;

  hfc_md_counter #(
    .CNT_W    (CNT_W),
    .LOAD_VAL (MD_LATENCY - 1)
  ) u_md_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .zero  (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next state and counter control; a mul/div entering EX always takes precedence.
  always_comb begin
    state_next = state;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    case (state)
      RUN: begin
        if (md_enter) begin
          state_next = MD_WAIT;
          cnt_load   = 1'b1;
        end else if (load_use && !flush_ex) begin
          state_next = LOAD_STALL;
        end
      end
      LOAD_STALL: begin
        if (md_enter) begin
          state_next = MD_WAIT;
          cnt_load   = 1'b1;
        end else begin
          state_next = RUN;
        end
      end
      MD_WAIT: begin
        if (md_enter) begin
          cnt_load = 1'b1;
        end else if (cnt_zero) begin
          state_next = RUN;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_next = RUN;
    endcase
  end

  // Stall/bubble outputs; flush suppresses the PC hold but still bubbles EX.
  always_comb begin
    md_hazard    = 1'b0;
    stall_pc     = 1'b0;
    bubble_rr_ex = flush_ex;
    case (state)
      RUN: begin
        stall_pc     = load_use && !flush_ex;
        bubble_rr_ex = load_use || flush_ex;
      end
      MD_WAIT: begin
        md_hazard    = !cnt_zero && valid_rr && md_use_rr;
        stall_pc     = (load_use || md_hazard) && !flush_ex;
        bubble_rr_ex = load_use || md_hazard || flush_ex;
      end
      default: begin
        stall_pc     = 1'b0;
        bubble_rr_ex = flush_ex;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_busy <= 1'b0;
    end else begin
      md_busy <= (state_next == MD_WAIT);
    end
  end

  // A load result is not available at EX/MM; the load-use stall must prevent this.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(ex_mm.memread && ((Forwarding_control_1 == FWD_EXMM) ||
                                  (Forwarding_control_2 == FWD_EXMM))));
    end
  end

endmodule

// File: tb/tb_hazard_forwarding_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations, then
// random instruction streams compared every cycle against a tag-level model.
module tb_hazard_forwarding_ctrl;

  localparam int LAT = 4;

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       mds;
    logic       mdu;
  } ins_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  ins_t cur = '0;
  logic flush = 1'b0;
  logic chk_on = 1'b0;

  logic       valid_rr, use_rs_rr, use_rt_rr, regwrite_rr, memread_rr;
  logic       md_start_rr, md_use_rr, flush_ex;
  logic [4:0] rs_rr, rt_rr, rd_rr;
  logic [1:0] fc1, fc2;
  logic       stall_pc, bubble_rr_ex, md_busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign valid_rr    = cur.v;
  assign rs_rr       = cur.rs;
  assign rt_rr       = cur.rt;
  assign use_rs_rr   = cur.urs;
  assign use_rt_rr   = cur.urt;
  assign rd_rr       = cur.rd;
  assign regwrite_rr = cur.rw;
  assign memread_rr  = cur.mr;
  assign md_start_rr = cur.mds;
  assign md_use_rr   = cur.mdu;
  assign flush_ex    = flush;

  hazard_forwarding_ctrl #(
    .REG_AW     (5),
    .MD_LATENCY (LAT),
    .CNT_W      (3)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .valid_rr             (valid_rr),
    .rs_rr                (rs_rr),
    .rt_rr                (rt_rr),
    .use_rs_rr            (use_rs_rr),
    .use_rt_rr            (use_rt_rr),
    .rd_rr                (rd_rr),
    .regwrite_rr          (regwrite_rr),
    .memread_rr           (memread_rr),
    .md_start_rr          (md_start_rr),
    .md_use_rr            (md_use_rr),
    .flush_ex             (flush_ex),
    .Forwarding_control_1 (fc1),
    .Forwarding_control_2 (fc2),
    .stall_pc             (stall_pc),
    .bubble_rr_ex         (bubble_rr_ex),
    .md_busy              (md_busy)
  );

  // Model: EX, MM, WB occupants as whole instructions, plus cycles of mul/div occupancy left.
  ins_t ex_i, mm_i, wb_i;
  int   md_left;
  logic e_lu, e_md, e_stall, e_bubble, e_busy;
  logic [1:0] e_f1, e_f2;
  ins_t e_next;

  function automatic logic [1:0] fsel(input ins_t e, input ins_t m, input ins_t w,
                                      input logic [4:0] r, input logic u);
    if (!e.v || !u || r == 5'd0) return 2'd0;
    if (m.rw && m.rd == r) return 2'd1;
    if (w.rw && w.rd == r) return 2'd2;
    return 2'd0;
  endfunction

  always_comb begin
    e_lu = cur.v && ex_i.mr && (ex_i.rd != 5'd0) &&
           ((cur.urs && cur.rs == ex_i.rd) || (cur.urt && cur.rt == ex_i.rd));
    e_md     = cur.v && cur.mdu && (md_left > 1);
    e_stall  = !flush && (e_lu || e_md);
    e_bubble = flush || e_lu || e_md;
    e_busy   = (md_left > 0);
    e_f1     = fsel(ex_i, mm_i, wb_i, ex_i.rs, ex_i.urs);
    e_f2     = fsel(ex_i, mm_i, wb_i, ex_i.rt, ex_i.urt);
    e_next   = e_bubble ? '0 : cur;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_i    <= '0;
      mm_i    <= '0;
      wb_i    <= '0;
      md_left <= 0;
    end else begin
      ex_i <= e_next;
      mm_i <= ex_i;
      wb_i <= mm_i;
      if (ex_i.mds) md_left <= LAT;
      else if (md_left > 0) md_left <= md_left - 1;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      chk("fwd1", int'(fc1), int'(e_f1));
      chk("fwd2", int'(fc2), int'(e_f2));
      chk("stall_pc", int'(stall_pc), int'(e_stall));
      chk("bubble", int'(bubble_rr_ex), int'(e_bubble));
      chk("md_busy", int'(md_busy), int'(e_busy));
    end
  end

  function automatic ins_t alu(input int rd, input int rs, input int rt);
    ins_t i = '0;
    i.v = 1'b1; i.rs = 5'(rs); i.rt = 5'(rt); i.urs = 1'b1; i.urt = 1'b1;
    i.rd = 5'(rd); i.rw = 1'b1;
    return i;
  endfunction

  function automatic ins_t ld(input int rd, input int rs);
    ins_t i = '0;
    i.v = 1'b1; i.rs = 5'(rs); i.urs = 1'b1; i.rd = 5'(rd); i.rw = 1'b1; i.mr = 1'b1;
    return i;
  endfunction

  function automatic ins_t mul(input int rs, input int rt);
    ins_t i = '0;
    i.v = 1'b1; i.rs = 5'(rs); i.rt = 5'(rt); i.urs = 1'b1; i.urt = 1'b1;
    i.mds = 1'b1; i.mdu = 1'b1;
    return i;
  endfunction

  function automatic ins_t mflo(input int rd);
    ins_t i = '0;
    i.v = 1'b1; i.rd = 5'(rd); i.rw = 1'b1; i.mdu = 1'b1;
    return i;
  endfunction

  function automatic ins_t rand_ins();
    ins_t i;
    int k;
    if ($urandom_range(0, 9) == 0) return '0;
    k = int'($urandom_range(0, 9));
    if (k <= 4)      i = alu(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    else if (k <= 6) i = ld(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    else if (k == 7) i = mul(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    else if (k == 8) i = mflo(int'($urandom_range(0, 7)));
    else begin
      i = alu(0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      i.rw = 1'b0;
    end
    return i;
  endfunction

  // Present one RR instruction for a cycle; returns at the sampling edge.
  task automatic put(input ins_t i, input logic f);
    @(posedge clk);
    #1;
    cur   = i;
    flush = f;
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_fwd1"}, int'(fc1), 0);
    chk({nm, "_fwd2"}, int'(fc2), 0);
    chk({nm, "_stall"}, int'(stall_pc), 0);
    chk({nm, "_bubble"}, int'(bubble_rr_ex), 0);
    chk({nm, "_busy"}, int'(md_busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    ins_t nxt;
    logic f;
    #3;
    chk_all_zero("reset");
    #9;
    rst_n  = 1'b1;
    chk_on = 1'b1;

    // ALU back-to-back on r3
    put(alu(3, 1, 2), 1'b0);
    put(alu(6, 3, 4), 1'b0); chk("b2b_pre_fwd1", int'(fc1), 0); chk("b2b_stall", int'(stall_pc), 0);
    put('0, 1'b0);           chk("b2b_fwd1", int'(fc1), 1); chk("b2b_fwd2", int'(fc2), 0);
    put('0, 1'b0);           chk("b2b_post_fwd1", int'(fc1), 0);

    // Two-apart dependency on r5, then double match
    put(alu(5, 1, 2), 1'b0);
    put(alu(7, 8, 9), 1'b0);
    put(alu(11, 1, 5), 1'b0);
    put('0, 1'b0);           chk("gap2_fwd2", int'(fc2), 2); chk("gap2_fwd1", int'(fc1), 0);
    put(alu(5, 1, 2), 1'b0);
    put(alu(5, 10, 11), 1'b0);
    put(alu(12, 13, 5), 1'b0);
    put('0, 1'b0);           chk("dbl_fwd2", int'(fc2), 1);

    // Load-use on r4
    put(ld(4, 1), 1'b0);
    put(alu(8, 4, 2), 1'b0); chk("lu_stall", int'(stall_pc), 1); chk("lu_bubble", int'(bubble_rr_ex), 1);
    put(alu(8, 4, 2), 1'b0); chk("lu_stall2", int'(stall_pc), 0); chk("lu_bubble2", int'(bubble_rr_ex), 0);
    put('0, 1'b0);           chk("lu_fwd1", int'(fc1), 2);

    // r0 producers never forward or stall
    put(alu(0, 1, 2), 1'b0);
    put(alu(13, 0, 0), 1'b0);
    put('0, 1'b0);           chk("r0_fwd1", int'(fc1), 0); chk("r0_fwd2", int'(fc2), 0);
    put(ld(0, 1), 1'b0);
    put(alu(14, 0, 0), 1'b0); chk("r0_ld_stall", int'(stall_pc), 0);

    // mult, independent add, then mflo
    put(mul(1, 2), 1'b0);    chk("md_busy0", int'(md_busy), 0);
    put(alu(9, 3, 4), 1'b0); chk("md_add_stall", int'(stall_pc), 0);
    put(mflo(10), 1'b0);     chk("md_st1", int'(stall_pc), 1); chk("md_busy1", int'(md_busy), 1);
    put(mflo(10), 1'b0);     chk("md_st2", int'(stall_pc), 1);
    put(mflo(10), 1'b0);     chk("md_st3", int'(stall_pc), 1); chk("md_busy3", int'(md_busy), 1);
    put(mflo(10), 1'b0);     chk("md_st4", int'(stall_pc), 0); chk("md_busy4", int'(md_busy), 1);
    put('0, 1'b0);           chk("md_busy5", int'(md_busy), 0);

    // Load-use coinciding with a flush
    put(ld(4, 1), 1'b0);
    put(alu(8, 4, 2), 1'b1); chk("fl_stall", int'(stall_pc), 0); chk("fl_bubble", int'(bubble_rr_ex), 1);
    put('0, 1'b0);           chk("fl_stall2", int'(stall_pc), 0); chk("fl_bubble2", int'(bubble_rr_ex), 0);

    // Reset while a mul/div is stalling an mflo
    put(mul(1, 2), 1'b0);
    put(mflo(10), 1'b0);     chk("rst_pre_stall0", int'(stall_pc), 0);
    put(mflo(10), 1'b0);     chk("rst_pre_stall", int'(stall_pc), 1); chk("rst_pre_busy", int'(md_busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;

    // Random streams; RR holds its instruction while the model says stall
    for (int c = 0; c < 4000; c++) begin
      if (!e_stall) nxt = rand_ins();
      f = ($urandom_range(0, 19) == 0);
      put(nxt, f);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
